// File: rtl/isw_share_encoder.sv
// rtl/isw_share_encoder.sv - 3-share Boolean masking encoder feeding the ISW gadgets.
// Optional ENC_COUNT_EN adds a 16-bit output-handshake counter on enc_count.
module isw_share_encoder #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] rnd_data,
    input  logic           rnd_valid,
    output logic           rnd_ready,
    output logic [3*W-1:0] out_shares,
    output logic           out_valid,
    input  logic           out_ready
`ifdef ENC_COUNT_EN
    ,
    output logic [15:0]    enc_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RND = 2'd1,
        OUT      = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q;
    logic [3*W-1:0] shares_q;
    logic [W-1:0]   r0, r1;
    logic           in_accept, rnd_accept, out_accept;

    assign r0         = rnd_data[W-1:0];
    assign r1         = rnd_data[2*W-1:W];
    assign in_accept  = in_valid && in_ready;
    assign rnd_accept = rnd_valid && rnd_ready;
    assign out_accept = out_valid && out_ready;
    assign out_shares = shares_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (in_valid) state_d = WAIT_RND;
            WAIT_RND: if (rnd_valid) state_d = OUT;
            OUT:      if (out_ready) state_d = in_valid ? WAIT_RND : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Handshakes are suppressed while rst is high so nothing is accepted or consumed in reset.
    always_comb begin
        in_ready  = 1'b0;
        rnd_ready = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:     in_ready = 1'b1;
                WAIT_RND: rnd_ready = 1'b1;
                OUT: begin
                    out_valid = 1'b1;
                    in_ready  = out_ready;
                end
                default: ;
            endcase
        end
    end

    // s0 folds r0 into x_q before r1 so the unmasked value never meets a lone share.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            shares_q <= '0;
        end else begin
            if (rnd_accept) begin
                shares_q <= {r1, r0, (x_q ^ r0) ^ r1};
                x_q      <= '0;
            end else if (out_accept) begin
                shares_q <= '0;
            end
            if (in_accept) begin
                x_q <= in_data;
            end
        end
    end

`ifdef ENC_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'd0;
        end else if (out_accept) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign enc_count = count_q;
`endif

endmodule

// File: tb/tb_isw_share_encoder.sv
// tb/tb_isw_share_encoder.sv - self-checking bench for isw_share_encoder.
module tb_isw_share_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [23:0] out_shares;
    logic        out_valid;
    logic        out_ready;
`ifdef ENC_COUNT_EN
    logic [15:0] enc_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    isw_share_encoder #(.W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .out_shares (out_shares),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef ENC_COUNT_EN
        ,
        .enc_count  (enc_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0]  words [10];
    logic [7:0]  sent_q [$];
    logic [23:0] exp_q [$];
    logic [7:0]  x, r0, r1;
    logic [23:0] e;
    int          nsent, nrnd, nout, cyc;

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0;
        rnd_data = 16'h0000; rnd_valid = 1'b0; out_ready = 1'b0;
        nxt();
        chk("in_ready_in_reset", in_ready, 1'b0);
        nxt();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rnd_ready", rnd_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_shares", out_shares, 24'h0);
`ifdef ENC_COUNT_EN
        chk("rst_enc_count", enc_count, 16'h0);
`endif

        // Known vector with randomness always available, then downstream stall.
        in_data = 8'hA5; in_valid = 1'b1; rnd_data = 16'h3C0F; rnd_valid = 1'b1;
        nxt();
        in_valid = 1'b0;
        #1;
        chk("a_rnd_ready", rnd_ready, 1'b1);
        chk("a_out_valid_early", out_valid, 1'b0);
        chk("a_in_ready_wait", in_ready, 1'b0);
        nxt();
        rnd_data = 16'($urandom);
        #1;
        chk("a_out_valid", out_valid, 1'b1);
        chk("a_shares", out_shares, 24'h3C0F96);
        for (int i = 0; i < 4; i++) begin
            nxt();
            rnd_data = 16'($urandom);
            #1;
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_shares", out_shares, 24'h3C0F96);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_rnd_ready", rnd_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("out_in_ready_follows", in_ready, 1'b1);
        nxt();
        out_ready = 1'b0;
        #1;
        chk("a_idle_out_valid", out_valid, 1'b0);
        chk("a_idle_shares_cleared", out_shares, 24'h0);
        chk("a_idle_in_ready", in_ready, 1'b1);

        // Randomness withheld for five cycles.
        in_data = 8'h12; in_valid = 1'b1; rnd_valid = 1'b0;
        nxt();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("b_rnd_ready", rnd_ready, 1'b1);
            chk("b_out_valid", out_valid, 1'b0);
            if (i < 4) nxt();
        end
        rnd_valid = 1'b1; rnd_data = 16'hFFFF;
        nxt();
        rnd_valid = 1'b0;
        #1;
        chk("b_out_valid", out_valid, 1'b1);
        chk("b_shares", out_shares, 24'hFFFF12);
        out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;

        // Back-to-back stream of random words against a queue model.
        for (int i = 0; i < 10; i++) words[i] = 8'($urandom);
        nsent = 0; nrnd = 0; nout = 0; cyc = 0;
        in_valid = 1'b1; in_data = words[0]; rnd_valid = 1'b1; rnd_data = 16'($urandom);
        out_ready = 1'b1;
        #1;
        while (nout < 10 && cyc < 40) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("b2b_shares", out_shares, e);
                    chk("b2b_xor", out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16], words[nout]);
                end
                nout++;
            end
            if (rnd_valid && rnd_ready) begin
                if (sent_q.size() == 0) begin
                    chk("b2b_rnd_without_word", 1'b1, 1'b0);
                end else begin
                    x  = sent_q.pop_front();
                    r0 = rnd_data[7:0];
                    r1 = rnd_data[15:8];
                    exp_q.push_back({r1, r0, (x ^ r0) ^ r1});
                end
                nrnd++;
            end
            if (in_valid && in_ready) begin
                sent_q.push_back(in_data);
                nsent++;
            end
            nxt();
            cyc++;
            if (nsent < 10) in_data = words[nsent];
            else            in_valid = 1'b0;
            rnd_data = 16'($urandom);
            #1;
        end
        chk("b2b_outputs", nout, 10);
        chk("b2b_rnd_consumed", nrnd, 10);
        chk("b2b_cycles", cyc, 21);
        chk("b2b_idle_out_valid", out_valid, 1'b0);
`ifdef ENC_COUNT_EN
        chk("enc_count_total", enc_count, 16'd12);
`endif
        out_ready = 1'b0; rnd_valid = 1'b0;

        // Reset while waiting for randomness.
        in_data = 8'h5A; in_valid = 1'b1;
        nxt();
        in_valid = 1'b0; rst = 1'b1; rnd_valid = 1'b1;
        #1;
        chk("rstw_no_rnd_in_reset", rnd_ready, 1'b0);
        nxt();
        rst = 1'b0;
        #1;
        chk("rstw_out_valid", out_valid, 1'b0);
        chk("rstw_shares", out_shares, 24'h0);
        chk("rstw_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            chk("rstw_no_output", out_valid, 1'b0);
            chk("rstw_no_rnd", rnd_ready, 1'b0);
        end

        // Reset while holding an output.
        in_data = 8'hC3; in_valid = 1'b1;
        nxt();
        in_valid = 1'b0;
        nxt();
        rnd_valid = 1'b0;
        #1;
        chk("rsto_out_valid_before", out_valid, 1'b1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        chk("rsto_out_valid", out_valid, 1'b0);
        chk("rsto_shares", out_shares, 24'h0);
        chk("rsto_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            chk("rsto_no_output", out_valid, 1'b0);
        end
`ifdef ENC_COUNT_EN
        chk("enc_count_after_reset", enc_count, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
